mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 80 ++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-port memory arbiter: fetch port, data port and memory side.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wenable;
  logic        mem_renable;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
           mem_addr, mem_wdata, mem_wenable, mem_renable
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
           mem_addr, mem_wdata, mem_wenable, mem_renable
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-cycle memory between a fetch port and a data port.
// IDLE -> ACCESS -> DONE for legal accesses, IDLE -> DONE for misaligned/out-of-range ones.
module mem_arbiter #(
  parameter int unsigned MEM_BYTES = 64
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_e;

  localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);

  state_e      state_q;
  logic        last_q;   // 1 = data port granted last
  logic        id_q;     // 1 = data port owns the current access
  logic        we_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        any_req, pick_d, req_we, req_err;
  logic [31:0] req_addr;

  always_comb begin
    any_req  = bus.if_req | bus.d_req;
    pick_d   = (bus.if_req & bus.d_req) ? ~last_q : bus.d_req;
    req_addr = pick_d ? bus.d_addr : bus.if_addr;
    req_we   = pick_d & bus.d_we;
    req_err  = (req_addr[1:0] != 2'b00) || (req_addr > ADDR_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            id_q    <= pick_d;
            last_q  <= pick_d;
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= pick_d ? bus.d_wdata : '0;
            err_q   <= req_err;
            state_q <= req_err ? DONE : ACCESS;
          end
        end
        ACCESS:  state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic acc, done;
  assign acc  = (state_q == ACCESS);
  // A reset landing in DONE suppresses the ack rather than letting it leak out.
  assign done = (state_q == DONE) && !rst;

  assign bus.mem_addr    = acc ? addr_q : '0;
  assign bus.mem_renable = acc && !we_q;
  assign bus.mem_wenable = acc && we_q;
  assign bus.mem_wdata   = (acc && we_q) ? wdata_q : '0;

  // Memory read data arrives one cycle after the strobe, i.e. in DONE.
  assign bus.if_ack   = done && !id_q;
  assign bus.if_err   = done && !id_q && err_q;
  assign bus.if_rdata = (done && !id_q && !err_q) ? bus.mem_rdata : '0;

  assign bus.d_ack    = done && id_q;
  assign bus.d_err    = done && id_q && err_q;
  assign bus.d_rdata  = (done && id_q && !err_q && !we_q) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences, random traffic vs a transaction model.
module tb_mem_arbiter;
  localparam int MB = 64;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.MEM_BYTES(MB)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Attached memory: registered read, word k preloaded with k.
  logic [31:0] mem [16];
  int n_wr = 0, n_rd = 0;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 16; k++) mem[k] <= 32'(k);
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_wenable) begin
        mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
        n_wr <= n_wr + 1;
      end
      if (bus.mem_renable) begin
        bus.mem_rdata <= mem[bus.mem_addr[5:2]];
        n_rd <= n_rd + 1;
      end
    end
  end

  logic [31:0] shadow [16];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > 32'(MB - 4));
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    if ($urandom_range(0, 15) == 0) return $urandom;
    a = 32'($urandom_range(0, 17) * 4);
    if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  // One isolated transaction on a port (1 = data); returns ack latency and response.
  task automatic xfer(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output int lat, output logic [31:0] rdata, output logic err,
                      output int other, output int strobes);
    int s0;
    s0 = n_wr + n_rd;
    lat = 0; other = 0; rdata = '0; err = 1'b0;
    if (port) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    for (int k = 1; k <= 10; k++) begin
      tick;
      if (port ? bus.if_ack : bus.d_ack) other++;
      if (port ? bus.d_ack : bus.if_ack) begin
        lat   = k;
        rdata = port ? bus.d_rdata : bus.if_rdata;
        err   = port ? bus.d_err : bus.if_err;
        break;
      end
    end
    bus.d_req = 1'b0; bus.if_req = 1'b0; bus.d_we = 1'b0;
    strobes = n_wr + n_rd - s0;
    if (port && we && lat != 0 && !bad_addr(addr)) shadow[addr[5:2]] = wdata;
    tick;
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t tv[13];

  initial begin
    int lat, other, stb, cyc, nack, t_if, t_d;
    logic [31:0] rd;
    logic er;
    int who[4];
    int when[4];
    logic [31:0] f_a, d_a, d_wd;
    logic d_w;
    int f_age, d_age;

    tv[0]  = '{1'b0, 1'b0, 32'h04,       32'h0,        1'b0, 32'h1,        2};
    tv[1]  = '{1'b1, 1'b1, 32'h20,       32'hDEADBEEF, 1'b0, 32'h0,        2};
    tv[2]  = '{1'b1, 1'b0, 32'h20,       32'h0,        1'b0, 32'hDEADBEEF, 2};
    tv[3]  = '{1'b1, 1'b0, 32'h06,       32'h0,        1'b1, 32'h0,        1};
    tv[4]  = '{1'b1, 1'b0, 32'h40,       32'h0,        1'b1, 32'h0,        1};
    tv[5]  = '{1'b1, 1'b0, 32'h3C,       32'h0,        1'b0, 32'hF,        2};
    tv[6]  = '{1'b1, 1'b1, 32'h03,       32'h11111111, 1'b1, 32'h0,        1};
    tv[7]  = '{1'b0, 1'b0, 32'h02,       32'h0,        1'b1, 32'h0,        1};
    tv[8]  = '{1'b1, 1'b1, 32'h3C,       32'hA5A50001, 1'b0, 32'h0,        2};
    tv[9]  = '{1'b0, 1'b0, 32'h3C,       32'h0,        1'b0, 32'hA5A50001, 2};
    tv[10] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0,        1};
    tv[11] = '{1'b0, 1'b0, 32'h00,       32'h0,        1'b0, 32'h0,        2};
    tv[12] = '{1'b1, 1'b0, 32'h1C,       32'h0,        1'b0, 32'h7,        2};

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    for (int k = 0; k < 16; k++) shadow[k] = 32'(k);
    rst = 1'b1; mem_init = 1'b1;
    tick;
    chk("rst_ctl", {26'b0, bus.if_ack, bus.if_err, bus.d_ack, bus.d_err, bus.mem_wenable, bus.mem_renable}, 32'h0);
    chk("rst_bus", bus.if_rdata | bus.d_rdata | bus.mem_addr | bus.mem_wdata, 32'h0);
    tick;
    rst = 1'b0; mem_init = 1'b0;
    tick;

    for (int i = 0; i < 13; i++) begin
      xfer(tv[i].port, tv[i].we, tv[i].addr, tv[i].wdata, lat, rd, er, other, stb);
      chk($sformatf("v%0d_lat", i), lat, tv[i].exp_lat);
      chk($sformatf("v%0d_rdata", i), rd, tv[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, tv[i].exp_err});
      chk($sformatf("v%0d_other_ack", i), other, 0);
      chk($sformatf("v%0d_strobes", i), stb, tv[i].exp_err ? 0 : 1);
    end

    // Both ports hammering: reset restores fetch priority for the first tie.
    rst = 1'b1; tick; rst = 1'b0; tick;
    bus.if_addr = 32'h08; bus.d_addr = 32'h0C; bus.d_we = 1'b0;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    cyc = 0; nack = 0;
    while (nack < 4 && cyc < 40) begin
      tick; cyc++;
      if (bus.if_ack) begin
        who[nack] = 0; when[nack] = cyc; nack++;
        chk("rr_if_rdata", bus.if_rdata, shadow[2]);
        bus.if_req = 1'b0;
      end else if (!bus.if_req) bus.if_req = 1'b1;
      if (bus.d_ack) begin
        who[nack] = 1; when[nack] = cyc; nack++;
        chk("rr_d_rdata", bus.d_rdata, shadow[3]);
        bus.d_req = 1'b0;
      end else if (!bus.d_req) bus.d_req = 1'b1;
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    chk("rr_acks", nack, 4);
    for (int k = 0; k < 4 && k < nack; k++) chk($sformatf("rr_who%0d", k), who[k], k % 2);
    for (int k = 1; k < 4 && k < nack; k++) chk($sformatf("rr_gap%0d", k), when[k] - when[k-1], 3);
    tick; tick;

    // Data request raised while the fetch sits in DONE.
    bus.if_addr = 32'h10; bus.if_req = 1'b1;
    t_if = 0; t_d = 0;
    for (int k = 1; k <= 20; k++) begin
      tick;
      if (bus.if_ack) begin
        t_if = k;
        chk("late_if_rdata", bus.if_rdata, 32'h4);
        bus.if_req = 1'b0;
        bus.d_addr = 32'h14; bus.d_we = 1'b0; bus.d_req = 1'b1;
      end
      if (bus.d_ack) begin
        t_d = k;
        chk("late_d_rdata", bus.d_rdata, 32'h5);
        bus.d_req = 1'b0;
        break;
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    chk("late_if_seen", {31'b0, t_if != 0}, 32'h1);
    chk("late_gap", t_d - t_if, 3);
    tick;

    // Reset during ACCESS of a write aborts the ack.
    bus.d_addr = 32'h08; bus.d_we = 1'b1; bus.d_wdata = 32'h12345678; bus.d_req = 1'b1;
    tick;
    chk("abort_wen_acc", {31'b0, bus.mem_wenable}, 32'h1);
    chk("abort_addr_acc", bus.mem_addr, 32'h08);
    chk("abort_wdata_acc", bus.mem_wdata, 32'h12345678);
    rst = 1'b1;
    tick;
    chk("abort_wen_after", {31'b0, bus.mem_wenable}, 32'h0);
    chk("abort_d_ack", {31'b0, bus.d_ack}, 32'h0);
    rst = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    nack = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (bus.d_ack || bus.mem_wenable) nack++;
    end
    chk("abort_quiet", nack, 0);
    shadow[2] = 32'h12345678;  // the write strobe reached memory before the reset edge
    xfer(1'b0, 1'b0, 32'h08, 32'h0, lat, rd, er, other, stb);
    chk("abort_idle_lat", lat, 2);
    chk("abort_idle_rdata", rd, 32'h12345678);

    // Random traffic on both ports against the transaction model.
    f_age = 0; d_age = 0; f_a = '0; d_a = '0; d_wd = '0; d_w = 1'b0;
    for (int c = 0; c < 600; c++) begin
      tick;
      if (bus.if_ack) begin
        chk("rnd_if_spurious", {31'b0, bus.if_req}, 32'h1);
        er = bad_addr(f_a);
        chk("rnd_if_err", {31'b0, bus.if_err}, {31'b0, er});
        chk("rnd_if_rdata", bus.if_rdata, er ? 32'h0 : shadow[f_a[5:2]]);
        bus.if_req = 1'b0; f_age = 0;
      end else begin
        chk("rnd_if_quiet", {31'b0, bus.if_err | (|bus.if_rdata)}, 32'h0);
        if (bus.if_req) begin
          f_age++;
          if (f_age > 8) begin
            chk("rnd_if_timeout", f_age, 8);
            bus.if_req = 1'b0; f_age = 0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          f_a = rnd_addr(); bus.if_addr = f_a; bus.if_req = 1'b1;
        end
      end
      if (bus.d_ack) begin
        chk("rnd_d_spurious", {31'b0, bus.d_req}, 32'h1);
        er = bad_addr(d_a);
        chk("rnd_d_err", {31'b0, bus.d_err}, {31'b0, er});
        chk("rnd_d_rdata", bus.d_rdata, (er || d_w) ? 32'h0 : shadow[d_a[5:2]]);
        if (!er && d_w) shadow[d_a[5:2]] = d_wd;
        bus.d_req = 1'b0; d_age = 0;
      end else begin
        chk("rnd_d_quiet", {31'b0, bus.d_err | (|bus.d_rdata)}, 32'h0);
        if (bus.d_req) begin
          d_age++;
          if (d_age > 8) begin
            chk("rnd_d_timeout", d_age, 8);
            bus.d_req = 1'b0; d_age = 0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          d_a = rnd_addr(); d_w = 1'($urandom_range(0, 1)); d_wd = $urandom;
          bus.d_addr = d_a; bus.d_we = d_w; bus.d_wdata = d_wd; bus.d_req = 1'b1;
        end
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick; tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
